conv_frame_sequencer: RTL and testbench

// - Frame-level controller in front of the conv+maxpool stream pipeline.
// - Gates an 8-bit pixel stream into the pipeline for exactly one IMG_W x IMG_H frame per start.
// - Monitors the 24-bit result handshake at the pipeline output and counts results.
// - Flags row ends and signals frame completion, abort or stall timeout to the host.

---
 rtl/conv_seq_pkg.sv | 19 +
 rtl/conv_seq_rowcol_cnt.sv | 42 ++++
 rtl/conv_frame_sequencer.sv | 135 +++++++++++++
 tb/tb_conv_frame_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and dimension helpers for the conv+maxpool frame sequencer.
package conv_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

  localparam int unsigned DEF_IMG_W   = 512;
  localparam int unsigned DEF_IMG_H   = 512;
  localparam int unsigned DEF_TIMEOUT = 65535;

  // 3x3 valid conv drops 2, then 2x2 maxpool halves.
  function automatic int unsigned out_dim(input int unsigned in_dim);
    return (in_dim - 2) / 2;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_seq_rowcol_cnt.sv
// Column/row position counter with wrap; reports last column and last row.
module conv_seq_rowcol_cnt
  import conv_seq_pkg::*;
#(
  parameter int unsigned W = 4,
  parameter int unsigned H = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic adv,
  output logic col_last,
  output logic row_last
);

  localparam int unsigned CW = cnt_w(W);
  localparam int unsigned RW = cnt_w(H);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  assign col_last = (col == CW'(W - 1));
  assign row_last = (row == RW'(H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller: gates one frame of pixels into the conv+maxpool
// pipeline per start and tracks results until completion, abort or timeout.
module conv_frame_sequencer
  import conv_seq_pkg::*;
#(
  parameter int unsigned IMG_W   = DEF_IMG_W,
  parameter int unsigned IMG_H   = DEF_IMG_H,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic        axi_clk,
  input  logic        axi_reset_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        s_pix_valid,
  input  logic [7:0]  s_pix_data,
  output logic        s_pix_ready,
  output logic        o_cm_valid,
  output logic [7:0]  o_cm_data,
  input  logic        i_cm_ready,
  input  logic        i_res_valid,
  input  logic        i_res_ready,
  output logic        o_res_last,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_intr,
  output logic [31:0] o_res_count
);

  localparam int unsigned OUT_W     = out_dim(IMG_W);
  localparam int unsigned OUT_H     = out_dim(IMG_H);
  localparam int unsigned OUT_TOTAL = OUT_W * OUT_H;
  localparam int unsigned CNT_W     = $clog2(OUT_TOTAL + 1);
  localparam int unsigned TW        = $clog2(TIMEOUT + 1);

  seq_state_t state, nxt;

  logic run_en, start_acc;
  logic in_beat, res_beat, last_in, done_evt, tmo_hit;
  logic in_col_last, in_row_last, res_col_last, res_row_last;
  logic [CNT_W-1:0] res_count;
  logic [TW-1:0]    tmo_cnt;

  assign o_cm_data   = s_pix_data;
  assign o_cm_valid  = s_pix_valid & run_en;
  assign s_pix_ready = i_cm_ready & run_en;

  assign in_beat  = s_pix_valid & s_pix_ready;
  assign res_beat = i_res_valid & i_res_ready & o_busy;
  assign last_in  = in_beat & in_col_last & in_row_last;
  // Final result detected from the result position counter, equivalent to
  // res_count reaching OUT_TOTAL on this beat.
  assign done_evt = res_beat & res_col_last & res_row_last;
  assign tmo_hit  = (state == DRAIN) & ~res_beat & (tmo_cnt == TW'(TIMEOUT - 1));

  assign o_res_last  = i_res_valid & res_col_last;
  assign o_res_count = 32'(res_count);

  conv_seq_rowcol_cnt #(.W(IMG_W), .H(IMG_H)) u_in_cnt (
    .clk      (axi_clk),
    .rst_n    (axi_reset_n),
    .clr      (start_acc),
    .adv      (in_beat),
    .col_last (in_col_last),
    .row_last (in_row_last)
  );

  conv_seq_rowcol_cnt #(.W(OUT_W), .H(OUT_H)) u_res_cnt (
    .clk      (axi_clk),
    .rst_n    (axi_reset_n),
    .clr      (start_acc),
    .adv      (res_beat),
    .col_last (res_col_last),
    .row_last (res_row_last)
  );

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) state <= IDLE;
    else              state <= nxt;
  end

  // Priority: abort > completion > timeout / end of input.
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (i_start) nxt = RUN;
      RUN: begin
        if (i_abort)       nxt = IDLE;
        else if (done_evt) nxt = DONE;
        else if (last_in)  nxt = DRAIN;
      end
      DRAIN: begin
        if (i_abort)       nxt = IDLE;
        else if (done_evt) nxt = DONE;
        else if (tmo_hit)  nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    run_en    = (state == RUN);
    o_busy    = (state == RUN) || (state == DRAIN);
    start_acc = i_start && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      o_intr <= 1'b0;
    end else if (start_acc) begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      o_intr <= 1'b0;
    end else begin
      o_intr <= (nxt == DONE) && (state != DONE);
      if ((nxt == DONE) && (state != DONE)) o_done <= 1'b1;
      if (o_busy && (nxt == IDLE))          o_err  <= 1'b1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n)  res_count <= '0;
    else if (start_acc) res_count <= '0;
    else if (res_beat)  res_count <= res_count + CNT_W'(1);
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n)                     tmo_cnt <= '0;
    else if ((state != DRAIN) || res_beat) tmo_cnt <= '0;
    else if (tmo_cnt != TW'(TIMEOUT))      tmo_cnt <= tmo_cnt + TW'(1);
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed scoreboard bench for conv_frame_sequencer (8x6 frame, timeout 16).
module tb_conv_frame_sequencer;

  localparam int OUT_W = 3;

  logic        axi_clk = 1'b0;
  logic        axi_reset_n;
  logic        i_start, i_abort;
  logic        s_pix_valid;
  logic [7:0]  s_pix_data;
  logic        s_pix_ready;
  logic        o_cm_valid;
  logic [7:0]  o_cm_data;
  logic        i_cm_ready;
  logic        i_res_valid, i_res_ready;
  logic        o_res_last, o_busy, o_done, o_err, o_intr;
  logic [31:0] o_res_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_intr = 0;
  logic [7:0] exp_pix[$];
  logic       exp_last[$];

  conv_frame_sequencer #(.IMG_W(8), .IMG_H(6), .TIMEOUT(16)) dut (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .s_pix_valid (s_pix_valid),
    .s_pix_data  (s_pix_data),
    .s_pix_ready (s_pix_ready),
    .o_cm_valid  (o_cm_valid),
    .o_cm_data   (o_cm_data),
    .i_cm_ready  (i_cm_ready),
    .i_res_valid (i_res_valid),
    .i_res_ready (i_res_ready),
    .o_res_last  (o_res_last),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_intr      (o_intr),
    .o_res_count (o_res_count)
  );

  always #5 axi_clk = ~axi_clk;

  always @(negedge axi_clk) if (o_intr) n_intr++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge axi_clk);
    #1;
  endtask

  task automatic pulse_start;
    tick; i_start = 1'b1;
    tick; i_start = 1'b0;
  endtask

  task automatic send_pixels(input int n, input bit bp);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 4000) begin
      tick;
      if (exp_pix.size() == 0) exp_pix.push_back(8'($urandom));
      s_pix_data  = exp_pix[0];
      s_pix_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      i_cm_ready  = bp ? cyc[0] : 1'b1;
      @(negedge axi_clk);
      if (s_pix_valid && !i_cm_ready) chk("stall_ready", {31'd0, s_pix_ready}, 32'd0);
      if (s_pix_valid && s_pix_ready) begin
        chk("pix_data", {24'd0, o_cm_data}, {24'd0, exp_pix.pop_front()});
        acc++;
      end
      cyc++;
    end
    chk("pix_accepted", acc, n);
    tick;
    s_pix_valid = 1'b0;
    i_cm_ready  = 1'b1;
  endtask

  task automatic send_results(input int n, input int first_idx);
    for (int k = 0; k < n; k++) begin
      tick;
      i_res_valid = 1'b1;
      i_res_ready = 1'b1;
      exp_last.push_back(((first_idx + k) % OUT_W) == OUT_W - 1);
      @(negedge axi_clk);
      chk("res_last", {31'd0, o_res_last}, {31'd0, exp_last.pop_front()});
    end
    tick;
    i_res_valid = 1'b0;
    i_res_ready = 1'b0;
  endtask

  initial begin
    int i0, k;
    axi_reset_n = 1'b0;
    i_start = 1'b0; i_abort = 1'b0;
    s_pix_valid = 1'b1; s_pix_data = 8'h00; i_cm_ready = 1'b1;
    i_res_valid = 1'b0; i_res_ready = 1'b0;

    // Reset
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    chk("rst_pix_ready", {31'd0, s_pix_ready}, 32'd0);
    chk("rst_cm_valid",  {31'd0, o_cm_valid}, 32'd0);
    chk("rst_flags", {28'd0, o_busy, o_done, o_err, o_intr}, 32'd0);
    chk("rst_count", o_res_count, 32'd0);
    chk("rst_res_last", {31'd0, o_res_last}, 32'd0);
    tick; axi_reset_n = 1'b1;
    @(negedge axi_clk);
    chk("post_rst_ready", {31'd0, s_pix_ready}, 32'd0);
    chk("post_rst_busy", {31'd0, o_busy}, 32'd0);
    s_pix_valid = 1'b0;

    // Nominal frame
    pulse_start;
    @(negedge axi_clk);
    chk("nom_busy", {31'd0, o_busy}, 32'd1);
    send_pixels(48, 1'b0);
    s_pix_valid = 1'b1;
    @(negedge axi_clk);
    chk("nom_ready_after_last", {31'd0, s_pix_ready}, 32'd0);
    chk("nom_drain_busy", {31'd0, o_busy}, 32'd1);
    s_pix_valid = 1'b0;
    i0 = n_intr;
    send_results(6, 0);
    @(negedge axi_clk);
    chk("nom_intr", {31'd0, o_intr}, 32'd1);
    chk("nom_done", {31'd0, o_done}, 32'd1);
    chk("nom_count", o_res_count, 32'd6);
    chk("nom_busy_end", {31'd0, o_busy}, 32'd0);
    chk("nom_err", {31'd0, o_err}, 32'd0);
    tick;
    @(negedge axi_clk);
    chk("nom_intr_clear", {31'd0, o_intr}, 32'd0);
    chk("nom_intr_count", n_intr - i0, 32'd1);

    // Backpressure
    pulse_start;
    send_pixels(48, 1'b1);
    s_pix_valid = 1'b1;
    @(negedge axi_clk);
    chk("bp_ready_after_last", {31'd0, s_pix_ready}, 32'd0);
    s_pix_valid = 1'b0;
    send_results(6, 0);
    @(negedge axi_clk);
    chk("bp_done", {31'd0, o_done}, 32'd1);
    chk("bp_count", o_res_count, 32'd6);

    // Timeout
    pulse_start;
    @(negedge axi_clk);
    chk("tmo_done_cleared", {31'd0, o_done}, 32'd0);
    send_pixels(48, 1'b0);
    send_results(5, 0);
    i0 = n_intr;
    k = 0;
    do begin
      @(negedge axi_clk);
      k++;
    end while (!o_err && k < 40);
    chk("tmo_latency", k, 32'd17);
    chk("tmo_busy", {31'd0, o_busy}, 32'd0);
    chk("tmo_done", {31'd0, o_done}, 32'd0);
    chk("tmo_count", o_res_count, 32'd5);
    chk("tmo_no_intr", n_intr - i0, 32'd0);

    // Result beat in IDLE is not counted
    tick; i_res_valid = 1'b1; i_res_ready = 1'b1;
    tick; i_res_valid = 1'b0; i_res_ready = 1'b0;
    @(negedge axi_clk);
    chk("idle_beat_ignored", o_res_count, 32'd5);

    // Abort after 20 pixels
    pulse_start;
    @(negedge axi_clk);
    chk("start_clears_err", {31'd0, o_err}, 32'd0);
    send_pixels(20, 1'b0);
    i_abort = 1'b1; s_pix_valid = 1'b1;
    tick;
    i_abort = 1'b0;
    @(negedge axi_clk);
    chk("abort_ready", {31'd0, s_pix_ready}, 32'd0);
    chk("abort_err", {31'd0, o_err}, 32'd1);
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    s_pix_valid = 1'b0;
    pulse_start;
    @(negedge axi_clk);
    chk("restart_err_cleared", {31'd0, o_err}, 32'd0);
    send_pixels(48, 1'b0);
    send_results(6, 0);
    @(negedge axi_clk);
    chk("restart_done", {31'd0, o_done}, 32'd1);
    chk("restart_count", o_res_count, 32'd6);

    // Result beat in DONE is not counted
    tick; i_res_valid = 1'b1; i_res_ready = 1'b1;
    tick; i_res_valid = 1'b0; i_res_ready = 1'b0;
    @(negedge axi_clk);
    chk("done_beat_ignored", o_res_count, 32'd6);

    // Start while busy, then abort together with the final result
    pulse_start;
    send_results(2, 0);
    @(negedge axi_clk);
    chk("early_results", o_res_count, 32'd2);
    tick; i_start = 1'b1;
    tick; i_start = 1'b0;
    @(negedge axi_clk);
    chk("busy_start_ignored", o_res_count, 32'd2);
    chk("busy_start_busy", {31'd0, o_busy}, 32'd1);
    send_pixels(48, 1'b0);
    send_results(3, 2);
    i0 = n_intr;
    tick; i_res_valid = 1'b1; i_res_ready = 1'b1; i_abort = 1'b1;
    tick; i_res_valid = 1'b0; i_res_ready = 1'b0; i_abort = 1'b0;
    @(negedge axi_clk);
    chk("abort_final_err", {31'd0, o_err}, 32'd1);
    chk("abort_final_done", {31'd0, o_done}, 32'd0);
    chk("abort_final_busy", {31'd0, o_busy}, 32'd0);
    tick;
    @(negedge axi_clk);
    chk("abort_final_no_intr", n_intr - i0, 32'd0);

    // Async reset mid-frame
    pulse_start;
    send_pixels(10, 1'b0);
    i0 = n_intr;
    #2 axi_reset_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("async_rst_count", o_res_count, 32'd0);
    tick; axi_reset_n = 1'b1;
    @(negedge axi_clk);
    chk("async_rst_no_intr", n_intr - i0, 32'd0);
    chk("async_rst_idle", {31'd0, o_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
